// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings for the logic-op pipeline.
package alu_pkg;

    typedef enum logic [4:0] {
        LOGOP_XNOR = 5'd10,
        LOGOP_XOR  = 5'd11,
        LOGOP_NOR  = 5'd12,
        LOGOP_ANDN = 5'd13,
        LOGOP_OR   = 5'd14,
        LOGOP_AND  = 5'd15
    } logop_e;

endpackage

// File: rtl/logop_stage.sv
// One valid/ready register stage carrying a logic-op result and its flags.
module logop_stage #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    input  logic              up_zero,
    input  logic              up_illegal,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic              dn_zero,
    output logic              dn_illegal
);

    logic load;

    // Load when empty or when the held entry leaves this cycle.
    assign load = ~dn_valid | dn_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            dn_valid   <= 1'b0;
            dn_data    <= '0;
            dn_zero    <= 1'b0;
            dn_illegal <= 1'b0;
        end else if (load) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data    <= up_data;
                dn_zero    <= up_zero;
                dn_illegal <= up_illegal;
            end
        end
    end

endmodule

// File: rtl/logop_pipe.sv
// Pipelined bitwise logic unit: decode + compute ahead of stage 1, then
// PIPE_STAGES bubble-free valid/ready stages with occupancy tracking.
module logop_pipe
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                               soc_clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_W-1:0]                  ALU_dat1,
    input  logic [DATA_W-1:0]                  ALU_dat2,
    input  logic [4:0]                         Instruction_to_ALU,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_W-1:0]                  LogOp_out,
    output logic                               LogOp_zero,
    output logic                               LogOp_illegal,
    output logic [$clog2(PIPE_STAGES+1)-1:0]   occupancy
);

    localparam int unsigned OCC_W = $clog2(PIPE_STAGES + 1);
    localparam int unsigned LAST  = PIPE_STAGES - 1;

    logic              accept;
    logic              retire;
    logic [DATA_W-1:0] res_c;
    logic              illegal_c;
    logic              zero_c;

    logic [PIPE_STAGES-1:0] stage_vld;
    logic [DATA_W-1:0]      stage_dat [PIPE_STAGES];
    logic                   stage_zero [PIPE_STAGES];
    logic                   stage_ill [PIPE_STAGES];
    logic [PIPE_STAGES:0]   load_c;

    // Opcode decode and result; unsupported opcodes yield 0 flagged illegal.
    always_comb begin
        res_c     = '0;
        illegal_c = 1'b0;
        case (Instruction_to_ALU)
            LOGOP_AND:  res_c = ALU_dat1 & ALU_dat2;
            LOGOP_OR:   res_c = ALU_dat1 | ALU_dat2;
            LOGOP_XOR:  res_c = ALU_dat1 ^ ALU_dat2;
            LOGOP_ANDN: res_c = ALU_dat1 & ~ALU_dat2;
            LOGOP_NOR:  res_c = ~(ALU_dat1 | ALU_dat2);
            LOGOP_XNOR: res_c = ~(ALU_dat1 ^ ALU_dat2);
            default:    illegal_c = 1'b1;
        endcase
    end

    assign zero_c = (res_c == '0);

    // Ready chain: a stage can load if it or any stage after it has room.
    always_comb begin
        load_c              = '0;
        load_c[PIPE_STAGES] = out_ready;
        for (int i = int'(PIPE_STAGES) - 1; i >= 0; i--) begin
            load_c[i] = ~stage_vld[i] | load_c[i+1];
        end
    end

    assign in_ready = load_c[0] & ~flush & ~reset;
    assign accept   = in_valid & in_ready;

    for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
        logic              up_v;
        logic [DATA_W-1:0] up_d;
        logic              up_z;
        logic              up_il;

        if (i == 0) begin : g_head
            assign up_v  = accept;
            assign up_d  = res_c;
            assign up_z  = zero_c;
            assign up_il = illegal_c;
        end else begin : g_body
            assign up_v  = stage_vld[i-1];
            assign up_d  = stage_dat[i-1];
            assign up_z  = stage_zero[i-1];
            assign up_il = stage_ill[i-1];
        end

        logop_stage #(.DATA_W(DATA_W)) u_stage (
            .clk        (soc_clk),
            .reset      (reset),
            .flush      (flush),
            .up_valid   (up_v),
            .up_data    (up_d),
            .up_zero    (up_z),
            .up_illegal (up_il),
            .dn_valid   (stage_vld[i]),
            .dn_ready   (load_c[i+1]),
            .dn_data    (stage_dat[i]),
            .dn_zero    (stage_zero[i]),
            .dn_illegal (stage_ill[i])
        );
    end

    assign out_valid     = stage_vld[LAST];
    assign LogOp_out     = stage_dat[LAST];
    assign LogOp_zero    = stage_zero[LAST];
    assign LogOp_illegal = stage_ill[LAST];
    assign retire        = out_valid & out_ready;

    // Entries in flight: accepts minus retires.
    always_ff @(posedge soc_clk) begin
        if (reset || flush) begin
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + OCC_W'(accept) - OCC_W'(retire);
        end
    end

endmodule

// File: tb/tb_logop_pipe.sv
// Bench for logop_pipe: queue-based reference model plus directed literal checks.
module tb_logop_pipe;

    localparam int PS = 2;

    logic        clk;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, dout;
    logic [4:0]  op;
    logic        zero, ill;
    logic [1:0]  occ;

    logic       rst8, fl8, iv8, ir8, ov8, or8, z8, il8;
    logic [7:0] a8, b8, o8;
    logic [4:0] op8;
    logic       occ8;

    int total = 0;
    int bad   = 0;

    logop_pipe #(.DATA_W(32), .PIPE_STAGES(2)) dut (
        .soc_clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .ALU_dat1(a), .ALU_dat2(b), .Instruction_to_ALU(op),
        .out_valid(out_valid), .out_ready(out_ready), .LogOp_out(dout),
        .LogOp_zero(zero), .LogOp_illegal(ill), .occupancy(occ)
    );

    logop_pipe #(.DATA_W(8), .PIPE_STAGES(1)) dut8 (
        .soc_clk(clk), .reset(rst8), .flush(fl8), .in_valid(iv8),
        .in_ready(ir8), .ALU_dat1(a8), .ALU_dat2(b8), .Instruction_to_ALU(op8),
        .out_valid(ov8), .out_ready(or8), .LogOp_out(o8),
        .LogOp_zero(z8), .LogOp_illegal(il8), .occupancy(occ8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics: {illegal, zero, result}.
    function automatic logic [33:0] ref_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        logic        il;
        r  = 32'h0;
        il = 1'b0;
        case (o)
            5'd15:   r = x & y;
            5'd14:   r = x | y;
            5'd11:   r = x ^ y;
            5'd13:   r = x & ~y;
            5'd12:   r = ~(x | y);
            5'd10:   r = ~(x ^ y);
            default: il = 1'b1;
        endcase
        return {il, (r == 32'h0), r};
    endfunction

    typedef struct {
        logic [31:0] d;
        logic        z;
        logic        il;
        int          acc;
    } item_t;

    item_t q[$];
    int    cyc     = 0;
    logic  armed   = 1'b0;
    logic  cleared = 1'b0;

    // Model: results leave in order; the head is visible once it is PS cycles old.
    always @(negedge clk) begin
        logic        exp_ov, exp_ir;
        int          n;
        item_t       it;
        logic [33:0] r;
        n      = q.size();
        exp_ov = (n > 0) && ((cyc - q[0].acc) >= PS);
        exp_ir = !reset && !flush && ((n < PS) || out_ready);
        if (armed) begin
            chk("m_out_valid", 64'(out_valid), 64'(exp_ov));
            chk("m_in_ready", 64'(in_ready), 64'(exp_ir));
            chk("m_occupancy", 64'(occ), 64'(n));
            if (exp_ov) begin
                chk("m_data", 64'(dout), 64'(q[0].d));
                chk("m_zero", 64'(zero), 64'(q[0].z));
                chk("m_illegal", 64'(ill), 64'(q[0].il));
            end else if (cleared) begin
                chk("m_cleared", {30'h0, ill, zero, dout}, 64'h0);
            end
        end
        cleared = 1'b0;
        if (reset || flush) begin
            q.delete();
            cleared = 1'b1;
        end else begin
            if (exp_ov && out_ready) void'(q.pop_front());
            if (in_valid && exp_ir) begin
                r      = ref_op(op, a, b);
                it.d   = r[31:0];
                it.z   = r[32];
                it.il  = r[33];
                it.acc = cyc;
                q.push_back(it);
            end
        end
        if (reset) armed = 1'b1;
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
    endtask

    logic [4:0]  ops3 [3];
    logic [31:0] exp3 [3];
    logic [4:0]  legal [6];

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 5'd0; a = 32'h0; b = 32'h0;
        rst8 = 1'b1; fl8 = 1'b0; iv8 = 1'b0; or8 = 1'b1;
        op8 = 5'd0; a8 = 8'h0; b8 = 8'h0;
        ops3[0] = 5'd14; ops3[1] = 5'd11; ops3[2] = 5'd12;
        exp3[0] = 32'hFFFF_FFFF; exp3[1] = 32'hFFFF_FFFF; exp3[2] = 32'h0;
        legal[0] = 5'd15; legal[1] = 5'd14; legal[2] = 5'd11;
        legal[3] = 5'd13; legal[4] = 5'd12; legal[5] = 5'd10;
        repeat (3) tick();

        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_occ", 64'(occ), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        chk("rst_outputs", {30'h0, ill, zero, dout}, 64'h0);
        reset = 1'b0;
        rst8  = 1'b0;
        #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'h1);

        // AND, latency 2
        send(5'd15, 32'hF0F0_1234, 32'h0FF0_FFFF);
        tick();
        in_valid = 1'b0;
        chk("and_lat1_valid", 64'(out_valid), 64'h0);
        tick();
        chk("and_valid", 64'(out_valid), 64'h1);
        chk("and_data", 64'(dout), 64'h00F0_1234);
        chk("and_zero", 64'(zero), 64'h0);

        // OR, XOR, NOR back to back
        for (int i = 0; i < 5; i++) begin
            if (i < 3) send(ops3[i], 32'hAAAA_AAAA, 32'h5555_5555);
            else in_valid = 1'b0;
            tick();
            if (i >= 1 && i <= 3) begin
                chk("b2b_valid", 64'(out_valid), 64'h1);
                chk("b2b_data", 64'(dout), 64'(exp3[i-1]));
                chk("b2b_zero", 64'(zero), 64'(exp3[i-1] == 32'h0));
            end
        end

        // Illegal opcode 3
        send(5'd3, 32'($urandom), 32'($urandom));
        tick();
        in_valid = 1'b0;
        tick();
        chk("ill_valid", 64'(out_valid), 64'h1);
        chk("ill_data", 64'(dout), 64'h0);
        chk("ill_flag", 64'(ill), 64'h1);
        chk("ill_zero", 64'(zero), 64'h1);
        tick();

        // Backpressure: two accepts then stall
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(5'd11, 32'h1111_1111 * 32'(i + 1), 32'h0);
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'(i < 2));
            if (i >= 2) chk("bp_hold", 64'(dout), 64'h1111_1111);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_occ", 64'(occ), 64'h2);
        chk("bp_valid", 64'(out_valid), 64'h1);
        out_ready = 1'b1;
        chk("bp_first", 64'(dout), 64'h1111_1111);
        tick();
        chk("bp_second_valid", 64'(out_valid), 64'h1);
        chk("bp_second", 64'(dout), 64'h2222_2222);
        tick();
        chk("bp_drained", 64'(out_valid), 64'h0);

        // Flush with full pipe and a presented input
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            send(5'd14, 32'(i + 1), 32'h0);
            tick();
        end
        send(5'd15, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        flush = 1'b1;
        #1;
        chk("fl_occ_before", 64'(occ), 64'h2);
        chk("fl_in_ready", 64'(in_ready), 64'h0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl_valid", 64'(out_valid), 64'h0);
        chk("fl_occ", 64'(occ), 64'h0);
        chk("fl_data", 64'(dout), 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fl_dropped", 64'(out_valid), 64'h0);
        end

        // Reset mid-stream
        for (int i = 0; i < 3; i++) begin
            send(5'd14, 32'($urandom) | 32'h1, 32'($urandom));
            tick();
        end
        reset = 1'b1;
        tick();
        chk("mr_valid", 64'(out_valid), 64'h0);
        chk("mr_outputs", {30'h0, ill, zero, dout}, 64'h0);
        chk("mr_occ", 64'(occ), 64'h0);
        chk("mr_in_ready", 64'(in_ready), 64'h0);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("mr_in_ready_after", 64'(in_ready), 64'h1);
        tick();
        chk("mr_no_output", 64'(out_valid), 64'h0);

        // DATA_W=8, PIPE_STAGES=1: XNOR, latency 1
        chk("w8_idle", 64'(ov8), 64'h0);
        iv8 = 1'b1; op8 = 5'd10; a8 = 8'h0F; b8 = 8'hFF;
        #1;
        chk("w8_in_ready", 64'(ir8), 64'h1);
        tick();
        iv8 = 1'b0;
        chk("w8_valid", 64'(ov8), 64'h1);
        chk("w8_data", 64'(o8), 64'h0F);
        chk("w8_flags", {62'h0, z8, il8}, 64'h0);
        tick();
        chk("w8_done", 64'(ov8), 64'h0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            r        = $urandom_range(0, 7);
            in_valid = ($urandom_range(0, 3) != 0);
            op       = (r < 6) ? legal[r] : 5'($urandom_range(0, 31));
            a        = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = ~a;
                default: b = $urandom;
            endcase
            out_ready = ((n / 50) % 3 == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            reset     = ($urandom_range(0, 249) == 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
